result_mux_hilo: RTL and testbench
==================================

Name: result_mux_hilo

Overview:
Parametrised, registered successor to the ALU result selector. It accepts one operation per handshake and selects the ALU, shifter, HI or LO source by function code. It owns the HI/LO register pair and sequences a multi-cycle external divider for DIVU, with an interlock and a timeout. It sits between the ALU/shifter/divider datapath and the register-file write port.

Parameters:
WIDTH, 32, data width of every operand, result and HI/LO register
FUNCT_W, 6, width of the function-code field
DIV_TIMEOUT, 64, maximum cycles spent in DIV_WAIT before abort (must be at least 2)

Ports:
clk  in  1  clock; all logic is rising-edge
reset  in  1  synchronous, active-high reset
op_valid  in  1  an operation is presented
op_funct  in  FUNCT_W  function code of the presented operation
op_ready  out  1  the block can accept an operation this cycle
alu_out  in  WIDTH  ALU result; also the data source for MTHI/MTLO
shift_out  in  WIDTH  shifter result
div_start  out  1  one-cycle pulse that starts the divider
div_done  in  1  divider result valid (a one-cycle pulse)
div_quot  in  WIDTH  divider quotient
div_rem  in  WIDTH  divider remainder
res_valid  out  1  res_data is valid for the register-file write, one-cycle pulse
res_data  out  WIDTH  registered result
hi_out  out  WIDTH  current HI register
lo_out  out  WIDTH  current LO register
illegal  out  1  one-cycle pulse: an unknown function code was accepted
div_err  out  1  sticky: a divide timed out; cleared only by reset

Behaviour:
- Function codes: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010, DIVU 011011, MFHI 010000, MFLO 010010, MTHI 010001, MTLO 010011.
- Reset (synchronous): state IDLE; res_valid 0; res_data 0; hi 0; lo 0; div_start 0; illegal 0; div_err 0; timeout counter 0. Reset takes priority over everything, including a divide in progress. A div_done arriving in the reset cycle is discarded.
- FSM states:
  - IDLE: op_ready=1.
  - DIV_START: op_ready=0, div_start=1 for exactly this cycle.
  - DIV_WAIT: op_ready=0.
- Acceptance: an operation is accepted when op_valid && op_ready. Outputs update on the edge that accepts; latency is 1 cycle, so res_valid is visible the cycle after acceptance.
- AND/OR/ADD/SUB/SLT: res_data<=alu_out, res_valid<=1.
- SRL: res_data<=shift_out, res_valid<=1.
- MFHI/MFLO: res_data<=hi/lo as held before the edge, res_valid<=1.
- MTHI/MTLO: hi/lo<=alu_out, res_valid<=0. A following MFHI or MFLO in the next accepted cycle sees the new value (no hazard).
- Unknown code: res_data<=0, res_valid<=1, illegal<=1.
- DIVU: res_valid<=0; IDLE->DIV_START; counter<=0. After DIV_START the FSM goes to DIV_WAIT unconditionally.
- DIV_WAIT:
  - div_done=1: lo<=div_quot, hi<=div_rem, then ->IDLE.
  - Otherwise counter increments. When counter reaches DIV_TIMEOUT-1 without div_done: div_err<=1, hi/lo unchanged, ->IDLE.
  - div_done and timeout in the same cycle: div_done wins.
- div_done is ignored in IDLE and DIV_START.
- res_valid and illegal deassert in any cycle without a fresh qualifying acceptance. res_data holds its last value.
- hi_out and lo_out are direct register outputs.
- Widths: all data paths are WIDTH bits. No sign or zero extension is performed. The counter is $clog2(DIV_TIMEOUT)+1 bits.

Decomposition:
- Shared package result_mux_pkg: function-code localparams (AND..MTLO), the FSM state enum {IDLE, DIV_START, DIV_WAIT}, and FUNCT_W.
- One natural sub-module: hilo_regs (the HI/LO pair with separate write enables and a dual-write from the divider).
- The FSM and result register stay in the top module.

Test Plan:
- Reset then ADD with alu_out=0x0000_0005 -> next cycle res_valid=1, res_data=0x5; following cycle res_valid=0.
- SRL with shift_out=0x8000_0000 and alu_out=0x1 -> res_data=0x8000_0000.
- MTHI alu_out=0xDEAD_BEEF, then MFHI -> no res_valid after MTHI; after MFHI res_valid=1, res_data=0xDEAD_BEEF; lo_out still 0.
- DIVU, then div_done after 10 cycles with quot=7, rem=3 -> div_start pulses exactly once; op_ready=0 throughout; then lo_out=7, hi_out=3, op_ready=1; MFLO returns 7.
- DIVU with no div_done, DIV_TIMEOUT=64 -> after 64 DIV_WAIT cycles div_err=1 and the FSM returns to IDLE; hi/lo unchanged; a late div_done in IDLE is ignored.
- Funct 111111 -> res_data=0, res_valid=1, illegal=1. Then a reset asserted mid-DIV_WAIT -> next cycle op_ready=1, hi=lo=0, div_err=0.

Source files
------------

// File: rtl/result_mux_pkg.sv
// result_mux_pkg
//   Shared definitions for result_mux_hilo and its HI/LO register file:
//   - the function-code field width and the decoded function codes
//   - the divide-sequencing FSM state encoding
package result_mux_pkg;

  localparam int FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] F_AND  = 6'b100100;
  localparam logic [FUNCT_W-1:0] F_OR   = 6'b100101;
  localparam logic [FUNCT_W-1:0] F_ADD  = 6'b100000;
  localparam logic [FUNCT_W-1:0] F_SUB  = 6'b100010;
  localparam logic [FUNCT_W-1:0] F_SLT  = 6'b101010;
  localparam logic [FUNCT_W-1:0] F_SRL  = 6'b000010;
  localparam logic [FUNCT_W-1:0] F_DIVU = 6'b011011;
  localparam logic [FUNCT_W-1:0] F_MFHI = 6'b010000;
  localparam logic [FUNCT_W-1:0] F_MFLO = 6'b010010;
  localparam logic [FUNCT_W-1:0] F_MTHI = 6'b010001;
  localparam logic [FUNCT_W-1:0] F_MTLO = 6'b010011;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIV_START = 2'd1,
    DIV_WAIT  = 2'd2
  } state_t;

endpackage : result_mux_pkg

// File: rtl/hilo_regs.sv
// hilo_regs
//   The HI/LO register pair. HI and LO each have their own write enable
//   (MTHI/MTLO), and the divider writes both at once (remainder -> HI,
//   quotient -> LO).
// Ports:
//   clk, reset        clock, synchronous active-high reset (clears HI and LO)
//   hi_we, lo_we      single-register writes of wdata
//   wdata             data for single-register writes
//   div_we            dual write from the divider; takes priority
//   div_quot/div_rem  divider results
//   hi_out, lo_out    current register contents
module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             div_we,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_rem,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_we) begin
      hi_d = div_rem;
      lo_d = div_quot;
    end else begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule : hilo_regs

// File: rtl/result_mux_hilo.sv
// result_mux_hilo
//   Registered result selector between the ALU/shifter/divider datapath and
//   the register-file write port. Accepts one operation per op_valid/op_ready
//   handshake, selects ALU, shifter, HI or LO by function code, owns HI/LO,
//   and sequences an external multi-cycle divider for DIVU with a timeout.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   op_valid/op_funct/op_ready operation handshake and function code
//   alu_out, shift_out         result sources (alu_out also feeds MTHI/MTLO)
//   div_start/div_done         divider start pulse / result-valid pulse
//   div_quot, div_rem          divider results
//   res_valid, res_data        registered register-file write
//   hi_out, lo_out             HI/LO register contents
//   illegal                    pulse: unknown function code accepted
//   div_err                    sticky: a divide timed out
module result_mux_hilo #(
  parameter int WIDTH       = 32,
  parameter int FUNCT_W     = 6,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [FUNCT_W-1:0] op_funct,
  output logic               op_ready,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic [WIDTH-1:0]   shift_out,
  output logic               div_start,
  input  logic               div_done,
  input  logic [WIDTH-1:0]   div_quot,
  input  logic [WIDTH-1:0]   div_rem,
  output logic               res_valid,
  output logic [WIDTH-1:0]   res_data,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out,
  output logic               illegal,
  output logic               div_err
);

  import result_mux_pkg::*;

  localparam int CNT_W = $clog2(DIV_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_err_q, div_err_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             illegal_q, illegal_d;

  logic accept;
  logic hi_we, lo_we, div_we;

  assign accept = op_valid && op_ready;

  // State register and all other flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_err_q   <= div_err_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      illegal_q   <= illegal_d;
    end
  end

  // Next-state logic, including the divide timeout counter
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_err_d = div_err_q;
    div_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && op_funct == F_DIVU) begin
          state_d = DIV_START;
          cnt_d   = '0;
        end
      end
      DIV_START: state_d = DIV_WAIT;
      DIV_WAIT: begin
        // A result arriving on the timeout cycle still counts as success.
        if (div_done) begin
          div_we  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          div_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    op_ready  = (state_q == IDLE);
    div_start = (state_q == DIV_START);
  end

  // Result selection; only evaluated on acceptance, which happens in IDLE
  always_comb begin
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    illegal_d   = 1'b0;
    hi_we       = 1'b0;
    lo_we       = 1'b0;
    if (accept) begin
      case (op_funct)
        F_AND, F_OR, F_ADD, F_SUB, F_SLT: begin
          res_data_d  = alu_out;
          res_valid_d = 1'b1;
        end
        F_SRL: begin
          res_data_d  = shift_out;
          res_valid_d = 1'b1;
        end
        F_MFHI: begin
          res_data_d  = hi_out;
          res_valid_d = 1'b1;
        end
        F_MFLO: begin
          res_data_d  = lo_out;
          res_valid_d = 1'b1;
        end
        F_MTHI: hi_we = 1'b1;
        F_MTLO: lo_we = 1'b1;
        F_DIVU: ;
        default: begin
          res_data_d  = '0;
          res_valid_d = 1'b1;
          illegal_d   = 1'b1;
        end
      endcase
    end
  end

  hilo_regs #(
    .WIDTH(WIDTH)
  ) u_hilo (
    .clk      (clk),
    .reset    (reset),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (alu_out),
    .div_we   (div_we),
    .div_quot (div_quot),
    .div_rem  (div_rem),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign illegal   = illegal_q;
  assign div_err   = div_err_q;

endmodule : result_mux_hilo

// File: tb/tb_result_mux_hilo.sv
module tb_result_mux_hilo;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         op_valid;
  logic [5:0]   op_funct;
  logic         op_ready;
  logic [W-1:0] alu_out, shift_out;
  logic         div_start, div_done;
  logic [W-1:0] div_quot, div_rem;
  logic         res_valid;
  logic [W-1:0] res_data, hi_out, lo_out;
  logic         illegal, div_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  result_mux_hilo #(.WIDTH(W), .FUNCT_W(6), .DIV_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_funct(op_funct),
    .op_ready(op_ready), .alu_out(alu_out), .shift_out(shift_out),
    .div_start(div_start), .div_done(div_done), .div_quot(div_quot),
    .div_rem(div_rem), .res_valid(res_valid), .res_data(res_data),
    .hi_out(hi_out), .lo_out(lo_out), .illegal(illegal), .div_err(div_err)
  );

  // Drives one operation at a negedge; the next negedge is after acceptance.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] s);
    op_valid = 1'b1; op_funct = f; alu_out = a; shift_out = s;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; op_valid = 1'b0; op_funct = '0; alu_out = '0; shift_out = '0;
    div_done = 1'b0; div_quot = '0; div_rem = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%0b exp=0", res_valid); end
    checks++; if (res_data !== 32'h0) begin failures++; $display("FAIL reset_res_data got=%h exp=0", res_data); end
    checks++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin failures++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi_out, lo_out); end
    checks++; if (op_ready !== 1'b1 || div_start !== 1'b0) begin failures++; $display("FAIL reset_ready_start got=%0b%0b exp=10", op_ready, div_start); end
    checks++; if (illegal !== 1'b0 || div_err !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=00", illegal, div_err); end
    $display("test_reset done");
  endtask

  task automatic test_add;
    issue(6'b100000, 32'h0000_0005, 32'h0);
    checks++; if (res_valid !== 1'b1 || res_data !== 32'h5) begin failures++; $display("FAIL add_result got=%0b/%h exp=1/00000005", res_valid, res_data); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b0 || res_data !== 32'h5) begin failures++; $display("FAIL add_deassert got=%0b/%h exp=0/00000005", res_valid, res_data); end
    $display("test_add done");
  endtask

  task automatic test_srl;
    issue(6'b000010, 32'h1, 32'h8000_0000);
    checks++; if (res_valid !== 1'b1 || res_data !== 32'h8000_0000) begin failures++; $display("FAIL srl_result got=%0b/%h exp=1/80000000", res_valid, res_data); end
    $display("test_srl done");
  endtask

  task automatic test_back_to_back;
    issue(6'b010001, 32'hDEAD_BEEF, 32'h0);   // MTHI
    checks++; if (res_valid !== 1'b0 || hi_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mthi got=%0b/%h exp=0/deadbeef", res_valid, hi_out); end
    issue(6'b010000, 32'h0, 32'h0);           // MFHI immediately after
    checks++; if (res_valid !== 1'b1 || res_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mfhi got=%0b/%h exp=1/deadbeef", res_valid, res_data); end
    checks++; if (lo_out !== 32'h0) begin failures++; $display("FAIL mthi_lo_untouched got=%h exp=0", lo_out); end
    issue(6'b010011, 32'h0000_1234, 32'h0);   // MTLO
    issue(6'b010010, 32'h0, 32'h0);           // MFLO immediately after
    checks++; if (res_valid !== 1'b1 || res_data !== 32'h1234) begin failures++; $display("FAIL mflo got=%0b/%h exp=1/00001234", res_valid, res_data); end
    checks++; if (hi_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mtlo_hi_untouched got=%h exp=deadbeef", hi_out); end
    $display("test_back_to_back done");
  endtask

  task automatic test_divu;
    int starts = 0;
    int not_ready = 0;
    int stray = 0;
    issue(6'b011011, 32'h0, 32'h0);
    // Hold an ADD request during the divide: it must not be accepted.
    op_valid = 1'b1; op_funct = 6'b100000; alu_out = 32'h99;
    for (int i = 0; i < 10; i++) begin
      if (div_start) starts++;
      if (op_ready) not_ready++;
      if (res_valid) stray++;
      if (i == 9) begin
        op_valid = 1'b0;
        div_done = 1'b1; div_quot = 32'd7; div_rem = 32'd3;
      end
      @(negedge clk);
    end
    div_done = 1'b0;
    checks++; if (starts !== 1) begin failures++; $display("FAIL div_start_count got=%0d exp=1", starts); end
    checks++; if (not_ready !== 0 || stray !== 0) begin failures++; $display("FAIL div_interlock got=ready%0d/valid%0d exp=0/0", not_ready, stray); end
    checks++; if (lo_out !== 32'd7 || hi_out !== 32'd3) begin failures++; $display("FAIL divu_hilo got=%h/%h exp=00000003/00000007", hi_out, lo_out); end
    checks++; if (op_ready !== 1'b1 || div_start !== 1'b0 || div_err !== 1'b0) begin failures++; $display("FAIL divu_idle got=%0b%0b%0b exp=100", op_ready, div_start, div_err); end
    issue(6'b010010, 32'h0, 32'h0);           // MFLO
    checks++; if (res_valid !== 1'b1 || res_data !== 32'd7) begin failures++; $display("FAIL divu_mflo got=%0b/%h exp=1/00000007", res_valid, res_data); end
    $display("test_divu done");
  endtask

  // div_done on the last allowed DIV_WAIT cycle must win over the timeout.
  task automatic test_done_at_timeout;
    issue(6'b011011, 32'h0, 32'h0);
    for (int i = 0; i < 64; i++) @(negedge clk);
    checks++; if (op_ready !== 1'b0) begin failures++; $display("FAIL edge_still_busy got=%0b exp=0", op_ready); end
    div_done = 1'b1; div_quot = 32'h100; div_rem = 32'h200;
    @(negedge clk);
    div_done = 1'b0;
    checks++; if (div_err !== 1'b0 || op_ready !== 1'b1) begin failures++; $display("FAIL edge_done_wins got=err%0b/ready%0b exp=0/1", div_err, op_ready); end
    checks++; if (hi_out !== 32'h200 || lo_out !== 32'h100) begin failures++; $display("FAIL edge_hilo got=%h/%h exp=00000200/00000100", hi_out, lo_out); end
    $display("test_done_at_timeout done");
  endtask

  task automatic test_timeout;
    issue(6'b011011, 32'h0, 32'h0);
    for (int i = 0; i < 64; i++) @(negedge clk);
    checks++; if (op_ready !== 1'b0 || div_err !== 1'b0) begin failures++; $display("FAIL timeout_early got=ready%0b/err%0b exp=0/0", op_ready, div_err); end
    @(negedge clk);
    checks++; if (div_err !== 1'b1 || op_ready !== 1'b1) begin failures++; $display("FAIL timeout_fire got=err%0b/ready%0b exp=1/1", div_err, op_ready); end
    checks++; if (hi_out !== 32'h200 || lo_out !== 32'h100) begin failures++; $display("FAIL timeout_hilo got=%h/%h exp=00000200/00000100", hi_out, lo_out); end
    div_done = 1'b1; div_quot = 32'hAA; div_rem = 32'hBB;
    @(negedge clk);
    div_done = 1'b0;
    checks++; if (hi_out !== 32'h200 || lo_out !== 32'h100 || div_err !== 1'b1) begin failures++; $display("FAIL late_done got=%h/%h err%0b exp=00000200/00000100 err1", hi_out, lo_out, div_err); end
    $display("test_timeout done");
  endtask

  task automatic test_illegal_reset;
    issue(6'b111111, 32'h55, 32'h66);
    checks++; if (res_data !== 32'h0 || res_valid !== 1'b1 || illegal !== 1'b1) begin failures++; $display("FAIL illegal got=%h/%0b/%0b exp=0/1/1", res_data, res_valid, illegal); end
    @(negedge clk);
    checks++; if (illegal !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL illegal_pulse got=%0b/%0b exp=0/0", illegal, res_valid); end
    issue(6'b011011, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) @(negedge clk);
    reset = 1'b1; div_done = 1'b1; div_quot = 32'h11; div_rem = 32'h22;
    @(negedge clk);
    reset = 1'b0; div_done = 1'b0;
    checks++; if (op_ready !== 1'b1 || div_err !== 1'b0) begin failures++; $display("FAIL mid_reset_ctl got=ready%0b/err%0b exp=1/0", op_ready, div_err); end
    checks++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin failures++; $display("FAIL mid_reset_hilo got=%h/%h exp=0/0", hi_out, lo_out); end
    @(negedge clk);
    checks++; if (op_ready !== 1'b1 || div_start !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%0b%0b exp=10", op_ready, div_start); end
    $display("test_illegal_reset done");
  endtask

  initial begin
    test_reset();
    test_add();
    test_srl();
    test_back_to_back();
    test_divu();
    test_done_at_timeout();
    test_timeout();
    test_illegal_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_result_mux_hilo
